// File: rtl/conv1_seq.sv
// ============================================================================
// conv1_seq : sequencer for the binary-activation conv/maxpool accumulator.
//             Buffers a binary map, walks 3x3 pooling windows, streams results.
// Revision  : 1.0
// ============================================================================
`default_nettype none

module conv1_seq #(
    parameter int IMG_W = 14,
    parameter int IMG_H = 14
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             row_we,
    input  logic [3:0]       row_addr,
    input  logic [IMG_W-1:0] row_data,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [8:0]       act,
    output logic [3:0]       sel,
    output logic             conv_we,
    output logic             conv_clr,
    output logic             acc_con,
    input  logic [5:0]       cmp,
    output logic             res_valid,
    output logic [5:0]       res_data,
    output logic [3:0]       res_idx
);

    localparam int POOL_W = (IMG_W - 2) / 3;
    localparam int POOL_H = (IMG_H - 2) / 3;
    localparam int NWIN   = POOL_W * POOL_H;
    localparam int RW     = $clog2(IMG_H);
    localparam int CW     = $clog2(IMG_W);
    localparam int PRW    = (POOL_H > 1) ? $clog2(POOL_H) : 1;
    localparam int PCW    = (POOL_W > 1) ? $clog2(POOL_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WCLR = 2'd1,
        S_ACC  = 2'd2,
        S_CAP  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [IMG_W-1:0] r_buf [IMG_H];
    logic [3:0]       r_tap;
    logic [1:0]       r_kr;
    logic [1:0]       r_kc;
    logic [PRW-1:0]   r_pr;
    logic [PCW-1:0]   r_pc;
    logic [3:0]       r_win;
    logic             r_done;
    logic             r_res_valid;
    logic [5:0]       r_res_data;
    logic [3:0]       r_res_idx;

    logic             w_last_tap;
    logic             w_last_win;
    logic             w_wr_ok;
    logic [RW-1:0]    w_waddr;
    logic [RW-1:0]    w_rbase;
    logic [CW-1:0]    w_cbase;
    logic [8:0]       w_pix;

    assign w_last_tap = (r_tap == 4'd8);
    assign w_last_win = (r_win == 4'(NWIN - 1));
    assign w_wr_ok    = row_we && (int'(row_addr) < IMG_H);
    assign w_waddr    = row_addr[RW-1:0];

    // Top-left pixel of the 3x3 conv patch for the current window and tap
    assign w_rbase = RW'(int'(r_pr) * 3 + int'(r_kr));
    assign w_cbase = CW'(int'(r_pc) * 3 + int'(r_kc));

    generate
        for (genvar i = 0; i < 9; i++) begin : g_lane
            logic [RW-1:0] w_row;
            logic [CW-1:0] w_col;
            assign w_row    = w_rbase + RW'(i / 3);
            assign w_col    = w_cbase + CW'(i % 3);
            assign w_pix[i] = r_buf[w_row][w_col];
        end
    endgenerate

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        act         = 9'd0;
        sel         = 4'd0;
        conv_we     = 1'b1;
        conv_clr    = 1'b0;
        acc_con     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_WCLR;
                end
            end
            S_WCLR: begin
                busy        = 1'b1;
                conv_clr    = 1'b1;
                w_state_nxt = S_ACC;
            end
            S_ACC: begin
                busy    = 1'b1;
                conv_we = 1'b0;
                sel     = r_tap;
                act     = w_pix;
                if (w_last_tap) begin
                    w_state_nxt = S_CAP;
                end
            end
            S_CAP: begin
                busy        = 1'b1;
                acc_con     = 1'b1;
                w_state_nxt = w_last_win ? S_IDLE : S_WCLR;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Row writes land only while idle, so a pass always sees a stable map
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            for (int r = 0; r < IMG_H; r++) begin
                r_buf[r] <= '0;
            end
        end else if (r_state == S_IDLE && w_wr_ok) begin
            r_buf[w_waddr] <= row_data;
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_tap       <= 4'd0;
            r_kr        <= 2'd0;
            r_kc        <= 2'd0;
            r_pr        <= '0;
            r_pc        <= '0;
            r_win       <= 4'd0;
            r_done      <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= 6'd0;
            r_res_idx   <= 4'd0;
        end else begin
            r_done      <= 1'b0;
            r_res_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_win <= 4'd0;
                        r_pr  <= '0;
                        r_pc  <= '0;
                    end
                end
                S_WCLR: begin
                    r_tap <= 4'd0;
                    r_kr  <= 2'd0;
                    r_kc  <= 2'd0;
                end
                S_ACC: begin
                    r_tap <= r_tap + 4'd1;
                    if (r_kc == 2'd2) begin
                        r_kc <= 2'd0;
                        r_kr <= r_kr + 2'd1;
                    end else begin
                        r_kc <= r_kc + 2'd1;
                    end
                end
                S_CAP: begin
                    r_res_valid <= 1'b1;
                    r_res_data  <= cmp;
                    r_res_idx   <= r_win;
                    if (w_last_win) begin
                        r_done <= 1'b1;
                    end else begin
                        r_win <= r_win + 4'd1;
                        if (r_pc == PCW'(POOL_W - 1)) begin
                            r_pc <= '0;
                            r_pr <= r_pr + PRW'(1);
                        end else begin
                            r_pc <= r_pc + PCW'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign done      = r_done;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_idx   = r_res_idx;

endmodule

`default_nettype wire

// File: tb/tb_conv1_seq.sv
// ============================================================================
// tb_conv1_seq : self-checking bench for conv1_seq with a behavioural
//                accumulator datapath and a window-schedule reference model.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_conv1_seq;

    localparam int IMG_W  = 14;
    localparam int IMG_H  = 14;
    localparam int POOL_W = 4;
    localparam int NWIN   = 16;
    localparam int WCYC   = 11;

    logic             CLK = 1'b0;
    logic             CLR;
    logic             row_we;
    logic [3:0]       row_addr;
    logic [IMG_W-1:0] row_data;
    logic             start;
    logic             busy;
    logic             done;
    logic [8:0]       act;
    logic [3:0]       sel;
    logic             conv_we;
    logic             conv_clr;
    logic             acc_con;
    logic [5:0]       cmp;
    logic             res_valid;
    logic [5:0]       res_data;
    logic [3:0]       res_idx;

    conv1_seq #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .CLK(CLK), .CLR(CLR), .row_we(row_we), .row_addr(row_addr),
        .row_data(row_data), .start(start), .busy(busy), .done(done),
        .act(act), .sel(sel), .conv_we(conv_we), .conv_clr(conv_clr),
        .acc_con(acc_con), .cmp(cmp), .res_valid(res_valid),
        .res_data(res_data), .res_idx(res_idx)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural accumulator datapath ----------------
    int wt [9];
    int acc [9];
    int dp_max;

    always @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            for (int i = 0; i < 9; i++) acc[i] <= 0;
        end else if (conv_clr) begin
            for (int i = 0; i < 9; i++) acc[i] <= 0;
        end else if (!conv_we && sel < 4'd9) begin
            for (int i = 0; i < 9; i++)
                if (act[i]) acc[i] <= acc[i] + wt[sel];
        end
    end

    always_comb begin
        dp_max = acc[0];
        for (int i = 1; i < 9; i++)
            if (acc[i] > dp_max) dp_max = acc[i];
        cmp = acc_con ? 6'(dp_max >>> 6) : 6'd0;
    end

    // ---------------- reference model ----------------
    logic [IMG_W-1:0] img [IMG_H];
    bit               m_active = 1'b0;
    bit               m_final  = 1'b0;
    int               m_n      = 0;

    function automatic logic [8:0] exp_act(input int w, input int t);
        logic [8:0] a;
        int pr, pc;
        pr = w / POOL_W;
        pc = w % POOL_W;
        for (int i = 0; i < 9; i++)
            a[i] = img[3*pr + i/3 + t/3][3*pc + i%3 + t%3];
        return a;
    endfunction

    function automatic logic [5:0] exp_res(input int w);
        int best, s;
        best = -1000000;
        for (int i = 0; i < 9; i++) begin
            s = 0;
            for (int t = 0; t < 9; t++)
                if (img[3*(w/POOL_W) + i/3 + t/3][3*(w%POOL_W) + i%3 + t%3]) s += wt[t];
            if (s > best) best = s;
        end
        return 6'(best >>> 6);
    endfunction

    always @(posedge CLK) begin
        if (CLR) begin
            m_active = 1'b0;
            m_final  = 1'b0;
            for (int r = 0; r < IMG_H; r++) img[r] = '0;
        end else begin
            m_final = 1'b0;
            if (m_active) begin
                m_n++;
                if (m_n == NWIN * WCYC) begin
                    m_active = 1'b0;
                    m_final  = 1'b1;
                end
            end else begin
                if (row_we && row_addr < 4'(IMG_H)) img[row_addr] = row_data;
                if (start) begin
                    m_active = 1'b1;
                    m_n      = 0;
                end
            end
        end
        #1;
        if (!CLR) begin
            if (m_active) begin
                int p, w;
                bit in_acc;
                p      = m_n % WCYC;
                w      = m_n / WCYC;
                in_acc = (p >= 1 && p <= 9);
                chk("busy", 32'(busy), 32'd1);
                chk("done", 32'(done), 32'd0);
                chk("conv_clr", 32'(conv_clr), 32'(p == 0));
                chk("conv_we", 32'(conv_we), 32'(!in_acc));
                chk("acc_con", 32'(acc_con), 32'(p == 10));
                chk("sel", 32'(sel), in_acc ? 32'(p - 1) : 32'd0);
                chk("act", 32'(act), in_acc ? 32'(exp_act(w, p - 1)) : 32'd0);
                chk("res_valid", 32'(res_valid), 32'(p == 0 && m_n > 0));
                if (p == 0 && m_n > 0) begin
                    chk("res_idx", 32'(res_idx), 32'(w - 1));
                    chk("res_data", 32'(res_data), 32'(exp_res(w - 1)));
                end
            end else begin
                chk("idle_busy", 32'(busy), 32'd0);
                chk("idle_done", 32'(done), 32'(m_final));
                chk("idle_res_valid", 32'(res_valid), 32'(m_final));
                chk("idle_ctrl", {28'd0, conv_we, conv_clr, acc_con, 1'b0}, 32'h8);
                chk("idle_sel_act", {19'd0, sel, act}, 32'd0);
                if (m_final) begin
                    chk("final_res_idx", 32'(res_idx), 32'(NWIN - 1));
                    chk("final_res_data", 32'(res_data), 32'(exp_res(NWIN - 1)));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic chk_reset();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_act", 32'(act), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_ctrl", {29'd0, conv_we, conv_clr, acc_con}, 32'h4);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res", {22'd0, res_data, res_idx}, 32'd0);
    endtask

    task automatic write_row(input int r, input logic [IMG_W-1:0] d);
        @(negedge CLK);
        row_we   = 1'b1;
        row_addr = 4'(r);
        row_data = d;
        @(negedge CLK);
        row_we   = 1'b0;
    endtask

    task automatic load_fill(input logic [IMG_W-1:0] d);
        for (int r = 0; r < IMG_H; r++) write_row(r, d);
    endtask

    task automatic load_random();
        for (int r = 0; r < IMG_H; r++) write_row(r, IMG_W'($urandom));
    endtask

    task automatic set_wt(input int v);
        for (int t = 0; t < 9; t++) wt[t] = v;
    endtask

    task automatic rand_wt();
        for (int t = 0; t < 9; t++) wt[t] = int'($urandom_range(0, 255)) - 128;
    endtask

    task automatic run_pass(input int inj, input int abort, input int wr_row,
                            input logic [IMG_W-1:0] wr_data);
        int  cyc, pulses;
        bit  got_done;
        @(negedge CLK);
        start = 1'b1;
        if (wr_row >= 0) begin
            row_we   = 1'b1;
            row_addr = 4'(wr_row);
            row_data = wr_data;
        end
        @(posedge CLK);
        #2;
        start    = 1'b0;
        row_we   = 1'b0;
        cyc      = 0;
        pulses   = 0;
        got_done = 1'b0;
        while (cyc < 400 && !got_done) begin
            @(posedge CLK);
            #2;
            cyc++;
            if (res_valid) pulses++;
            if (done) got_done = 1'b1;
            if (cyc == inj) begin
                start    = 1'b1;
                row_we   = 1'b1;
                row_addr = 4'($urandom_range(0, IMG_H - 1));
                row_data = IMG_W'($urandom);
            end
            if (cyc == inj + 1) begin
                start  = 1'b0;
                row_we = 1'b0;
            end
            if (cyc == abort) begin
                CLR = 1'b1;
                #1;
                chk_reset();
                @(posedge CLK);
                @(negedge CLK);
                CLR = 1'b0;
                return;
            end
        end
        chk("done_latency", 32'(cyc), 32'(NWIN * WCYC));
        chk("pulse_count", 32'(pulses), 32'(NWIN));
    endtask

    initial begin
        CLR      = 1'b1;
        row_we   = 1'b0;
        row_addr = 4'd0;
        row_data = '0;
        start    = 1'b0;
        set_wt(0);
        repeat (3) @(posedge CLK);
        #1;
        chk_reset();
        @(negedge CLK);
        CLR = 1'b0;

        // all-zero map, large weights
        set_wt(127);
        chk("pin_zero", 32'(exp_res(3)), 32'd0);
        run_pass(-5, -5, -1, '0);

        // all-ones map, +8 and -8 weights
        load_fill('1);
        set_wt(8);
        chk("pin_ones_p8", 32'(exp_res(5)), 32'd1);
        run_pass(-5, -5, -1, '0);
        set_wt(-8);
        chk("pin_ones_m8", 32'(exp_res(9)), 32'h3E);
        run_pass(-5, -5, -1, '0);

        // single pixel (0,0), W1=64
        load_fill('0);
        write_row(0, 14'h0001);
        set_wt(0);
        wt[0] = 64;
        chk("pin_px00_w0", 32'(exp_res(0)), 32'd1);
        chk("pin_px00_w1", 32'(exp_res(1)), 32'd0);
        run_pass(-5, -5, -1, '0);

        // single pixel (4,7), W5=127
        write_row(0, 14'h0000);
        write_row(4, 14'h0080);
        set_wt(0);
        wt[4] = 127;
        chk("pin_px47_w6", 32'(exp_res(6)), 32'd1);
        chk("pin_px47_w5", 32'(exp_res(5)), 32'd0);
        chk("pin_px47_act", 32'(exp_act(6, 4)), 32'h001);
        run_pass(-5, -5, -1, '0);

        // start/row_we mid-pass are ignored
        load_random();
        rand_wt();
        run_pass(30, -5, -1, '0);

        // out-of-range row writes, then row_we together with start
        write_row(14, '1);
        write_row(15, '1);
        run_pass(-5, -5, 5, IMG_W'($urandom));

        // asynchronous reset mid-pass, buffer lost, then a fresh pass
        rand_wt();
        run_pass(-5, 50, -1, '0);
        repeat (3) @(negedge CLK);
        set_wt(127);
        run_pass(-5, -5, -1, '0);
        load_random();
        rand_wt();
        run_pass(-5, -5, -1, '0);

        for (int k = 0; k < 3; k++) begin
            load_random();
            rand_wt();
            run_pass(-5, -5, -1, '0);
        end

        repeat (3) @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
